// File: rtl/cs_pair_resolve_serial_if.sv
// Valid/ready bundle between the carry-save tree and the resolver.
// Master drives operands and out_ready; slave is the resolver.
interface cs_pair_resolve_serial_if #(
  parameter int OP_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_WIDTH-1:0]  in_op0;
  logic [OP_WIDTH-1:0]  in_op1;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_sum;
  logic                 out_ovf;

  modport master (
    output in_valid, in_op0, in_op1, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_op0, in_op1, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/cs_pair_resolve_serial.sv
// Segmented carry-propagate resolver for a carry-save operand pair.
// Optional saturation on overflow: define CS_PAIR_RESOLVE_SAT_EN.
module cs_pair_resolve_serial #(
  parameter int OP_WIDTH  = 64,
  parameter int SEG_WIDTH = 16,
  parameter int OUT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  cs_pair_resolve_serial_if.slave bus
);

  localparam int NSEG = OP_WIDTH / SEG_WIDTH;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  if (OP_WIDTH % SEG_WIDTH != 0) begin : g_bad_seg
    $error("SEG_WIDTH must divide OP_WIDTH");
  end
  if (OUT_WIDTH > OP_WIDTH) begin : g_bad_out
    $error("OUT_WIDTH must not exceed OP_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t               state;
  state_t               state_d;
  logic [OP_WIDTH-1:0]  op0;
  logic [OP_WIDTH-1:0]  op1;
  logic [OP_WIDTH-1:0]  sum;
  logic [OP_WIDTH-1:0]  full;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic [SEG_WIDTH:0]   seg;
  logic                 last;
  int                   lo;
  logic [OP_WIDTH-OUT_WIDTH:0] top;
  logic                 ovf_d;
  logic [OUT_WIDTH-1:0] narrow;
  logic [OUT_WIDTH-1:0] sum_q;
  logic                 ovf_q;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;

  // Current segment add; full is the sum register with this segment merged,
  // so the narrowed result can be registered on the last ADD edge.
  always_comb begin
    lo   = int'(cnt) * SEG_WIDTH;
    seg  = {1'b0, op0[lo +: SEG_WIDTH]}
         + {1'b0, op1[lo +: SEG_WIDTH]}
         + {{SEG_WIDTH{1'b0}}, carry};
    full = sum;
    full[lo +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
    last = (cnt == CW'(NSEG - 1));
  end

  // Narrowing: overflow when the discarded top bits are not a sign extension.
  always_comb begin
    top   = full[OP_WIDTH-1:OUT_WIDTH-1];
    ovf_d = !((&top) || (~|top));
`ifdef CS_PAIR_RESOLVE_SAT_EN
    if (ovf_d)
      narrow = full[OP_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else
      narrow = full[OUT_WIDTH-1:0];
`else
    narrow = full[OUT_WIDTH-1:0];
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (bus.in_valid && bus.in_ready) state_d = ADD;
      ADD:  if (last) state_d = HOLD;
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Operand latch, per-segment accumulation and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op0   <= '0;
      op1   <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        op0   <= bus.in_op0;
        op1   <= bus.in_op1;
        carry <= 1'b0;
        cnt   <= '0;
      end
      if (state == ADD) begin
        sum   <= full;
        carry <= seg[SEG_WIDTH];
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum_q <= narrow;
          ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule

// File: doc/cs_pair_resolve_serial.md
Name: cs_pair_resolve_serial

Overview:
- Consumer end of the carry-save reduction tree. Accepts the two OP_WIDTH operands the tree emits and resolves them into one binary two's-complement sum.
- Uses a segmented, multi-cycle carry-propagate adder: SEG_WIDTH bits per cycle, with the carry kept in a register between segments.
- Final result is narrowed to OUT_WIDTH bits for the FIR output path, with an overflow flag.
- Valid/ready handshake on both sides.

Parameters:
- OP_WIDTH, 64, width of each carry-save input operand (signed two's complement).
- SEG_WIDTH, 16, bits added per cycle. Must divide OP_WIDTH exactly; otherwise elaboration error.
- OUT_WIDTH, 32, result width. Must be <= OP_WIDTH; otherwise elaboration error.
- Derived: NSEG = OP_WIDTH / SEG_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_op0  in  OP_WIDTH  carry-save operand 0.
- in_op1  in  OP_WIDTH  carry-save operand 1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  OUT_WIDTH  resolved, narrowed sum.
- out_ovf  out  1  full sum not representable as signed OUT_WIDTH.

Behaviour:
- Reset: one clock and reset only; reset is synchronous and active-high (rst sampled on rising clk edge).
- Reset values: state=IDLE, out_valid=0, out_sum=0, out_ovf=0, segment counter=0, carry=0, operand/sum registers=0.
- in_ready = (state==IDLE) && !rst (combinational).
- IDLE:
  - On in_valid && in_ready: latch in_op0/in_op1, clear carry and counter, go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - Each cycle, for segment k = counter: {c, s} = op0[k] + op1[k] + carry.
  - Write s into sum register segment k; carry <= c; counter++.
  - After segment NSEG-1, go to HOLD. The final carry-out is discarded (sum is modulo 2^OP_WIDTH).
- Latency: accept in cycle 0, ADD in cycles 1..NSEG, out_valid high from cycle NSEG+1.
- Throughput: at most one result per NSEG+2 cycles.
- HOLD:
  - out_valid=1; out_sum and out_ovf are registered and held stable.
  - On out_ready go to IDLE; out_valid drops in the next cycle.
  - in_ready=0 throughout, so in_valid during ADD/HOLD is ignored. The upstream must hold its data.
- Narrowing: full = sum register (OP_WIDTH bits).
  - out_ovf = 1 iff full[OP_WIDTH-1:OUT_WIDTH-1] is not all-equal.
  - Default: out_sum = full[OUT_WIDTH-1:0] (wrap).
  - out_sum/out_ovf are computed when entering HOLD.
- OUT_WIDTH == OP_WIDTH: out_ovf is constantly 0.
- Reset mid-ADD or mid-HOLD: transaction is abandoned, no out_valid is produced, and all state returns to reset values on that edge.
- Simultaneous in_valid with out_valid&&out_ready in HOLD: the input is not accepted that cycle. It is accepted the cycle after, in IDLE.

Optional Feature:
- Macro: CS_PAIR_RESOLVE_SAT_EN.
- Defined: when out_ovf=1, out_sum saturates.
  - Value is 2^(OUT_WIDTH-1)-1 if full[OP_WIDTH-1]==0, else -2^(OUT_WIDTH-1).
  - out_ovf is still reported.
- Undefined: wrap behaviour as above; no saturation logic is synthesised.

Test Plan (OP_WIDTH=64, SEG_WIDTH=16, OUT_WIDTH=32):
- Carry between segments: op0=0x0000_0000_0000_FFFF, op1=0x1 -> out_sum=0x0001_0000, out_ovf=0; out_valid rises exactly 5 cycles after the accept cycle.
- Full carry ripple: op0=0xFFFF_FFFF_FFFF_FFFF, op1=0xFFFF_FFFF_FFFF_FFFE -> out_sum=0xFFFF_FFFD, out_ovf=0.
- Positive overflow: op0=0x0000_0000_7FFF_FFFF, op1=0x1 -> out_ovf=1; out_sum=0x8000_0000 (macro off), 0x7FFF_FFFF (macro on).
- Negative overflow: op0=0xFFFF_FFFF_8000_0000, op1=0xFFFF_FFFF_FFFF_FFFF -> out_ovf=1; out_sum=0x7FFF_FFFF (off), 0x8000_0000 (on).
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid=1 and out_sum/out_ovf stable, in_ready=0; a new in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-ADD: assert rst in ADD cycle 2 -> next cycle state IDLE, out_valid=0, in_ready=1 after rst drops; the next transaction (op0=5, op1=7) yields out_sum=12.
